flash_axi_reader: RTL and testbench
===================================

# flash_axi_reader

AXI4 read-only slave that turns bus read bursts into single-beat requests on the flash read port (`r_en` / `r_addr` / `r_data`, one-cycle read latency) of the simulation flash model. It sits directly upstream of the flash model, between the SoC peripheral crossbar and the flash. It decodes the flash window, walks FIXED/INCR bursts beat by beat, and returns each 64-bit word on the R channel with backpressure. Out-of-window or unsupported beats are answered with SLVERR without touching the flash.

## Interface

Parameters:
- `FLASH_BASE`, default `32'h1000_0000`: bus base address of the flash window.
- `FLASH_SIZE`, default `32'h0040_0000`: window size in bytes (4 MB); a power of two.
- `ID_W`, default `4`: AXI ID width.

Ports:
- `clock`  in  1: sole clock. All logic is on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `ar_valid`  in  1; `ar_ready`  out  1: AR handshake.
- `ar_id`  in  ID_W; `ar_addr`  in  32; `ar_len`  in  8; `ar_size`  in  3; `ar_burst`  in  2: AR payload.
- `r_valid`  out  1; `r_ready`  in  1: R handshake.
- `r_id`  out  ID_W; `r_data`  out  64; `r_resp`  out  2; `r_last`  out  1: R payload.
- `flash_r_en`  out  1: flash read strobe.
- `flash_r_addr`  out  32: byte offset into the flash, 8-byte aligned.
- `flash_r_data`  in  64: flash word, valid the cycle after `flash_r_en`.

## Operation

- FSM states: IDLE, REQ, CAP, RESP.
- **IDLE**
  - `ar_ready`=1.
  - On `ar_valid && ar_ready`, latch id, addr, len, size and burst. Clear the beat counter. Go to REQ.
- **REQ** (one cycle)
  - Evaluate the current beat address A.
  - The beat is legal when all of these hold: `FLASH_BASE <= A < FLASH_BASE+FLASH_SIZE`, `size <= 3`, and `burst` is FIXED (00) or INCR (01).
  - Legal beat: `flash_r_en`=1 and `flash_r_addr` = (A − FLASH_BASE) with bits [2:0] cleared.
  - Illegal beat: `flash_r_en`=0 and an error flag is set.
  - Go to CAP.
- **CAP** (one cycle)
  - Load the R register: `r_data` = error ? 0 : `flash_r_data`; `r_resp` = error ? 2'b10 : 2'b00.
  - `r_last` = (beat counter == len); `r_id` = latched id.
  - Go to RESP.
- **RESP**
  - `r_valid`=1. Payload is held stable until `r_ready`.
  - On handshake with last beat: go to IDLE.
  - On handshake otherwise: increment the beat counter, advance A, go to REQ.
- **Address advance** (32-bit, wraps modulo 2^32):
  - FIXED: A is unchanged.
  - INCR: A = (A with the low `size` bits cleared) + (1 << `size`).
- **Beat data and errors:**
  - Narrow transfers (size < 3) return the full aligned 64-bit word. The master selects the byte lanes.
  - WRAP (10), reserved (11) and size > 3 produce SLVERR on every beat. Exactly len+1 beats are still returned and `r_last` is correct.
  - An INCR burst that crosses the window end returns OKAY for beats inside the window and SLVERR for beats beyond it.
- **Other rules:**
  - Only one burst is outstanding at a time. `ar_ready`=0 outside IDLE.
  - `flash_r_en` is asserted only in REQ for a legal beat, for exactly one cycle per beat. It is never asserted during an R stall.

## Timing

- **Reset values:**
  - FSM = IDLE.
  - `ar_ready`=0, `r_valid`=0, `flash_r_en`=0.
  - `r_data`=0, `r_resp`=0, `r_last`=0, `r_id`=0, `flash_r_addr`=0.
- `ar_ready` is a registered output. It rises on the first rising edge after `reset` deasserts, so no AR is accepted while `reset` is high.
- **Latency**, with AR handshake at cycle T:
  - `flash_r_en` at T+1.
  - `flash_r_data` sampled at T+2.
  - `r_valid` at T+3.
- **Subsequent beats**, with R handshake at cycle N:
  - Next `flash_r_en` at N+1.
  - Next `r_valid` at N+3.
  - Steady-state rate is 1 beat per 3 cycles when `r_ready` is held high.
- `ar_ready` reasserts the cycle after the last-beat R handshake.
- **Reset during a burst:**
  - All outputs return to their reset values immediately (asynchronously).
  - The burst is dropped. No further R beats are produced.
  - A new AR is accepted one cycle after release.
- An R stall of any length leaves `r_data`, `r_resp`, `r_last`, `r_id` and `flash_r_addr` unchanged.

## Test plan

- **Single read:** flash offset 0x8 = 64'h1122_3344_5566_7788. AR addr 0x1000_0008, len 0, size 3, INCR, id 5.
  - Expect one `flash_r_en` with `flash_r_addr`=0x8 at T+1.
  - Expect `r_valid` at T+3 with that data, `r_resp`=0, `r_last`=1, `r_id`=5.
- **INCR burst with stall:** INCR len 3 from 0x1000_0000, `r_ready` low for 5 cycles on beat 1.
  - Expect `flash_r_addr` sequence 0x0, 0x8, 0x10, 0x18.
  - Beat 1 payload is stable throughout the stall, and there is no `flash_r_en` during the stall.
  - `r_last` is set only on beat 3.
- **Out of range:** AR addr 0x1040_0000, len 0.
  - Expect no `flash_r_en`, and `r_data`=0, `r_resp`=2'b10, `r_last`=1.
- **Window crossing:** INCR len 1 from 0x103F_FFF8.
  - Beat 0 reads offset 0x3F_FFF8 with OKAY.
  - Beat 1 is SLVERR with no flash access.
- **FIXED and WRAP bursts:**
  - FIXED len 2 at 0x1000_0010 produces three reads, all at offset 0x10.
  - WRAP len 3 produces four SLVERR beats with zero `flash_r_en`.
- **Reset mid-burst:** assert `reset` while beat 1 of an INCR len 3 burst is in RESP.
  - `r_valid`, `flash_r_en` and `ar_ready` drop to 0 at once.
  - After release, `ar_ready`=1 on the next edge and a single read completes normally.

Source files
------------

// File: rtl/flash_axi_reader.sv
// flash_axi_reader
//   AXI4 read-only slave in front of the simulation flash model. Each AR burst
//   (FIXED or INCR) is walked one beat at a time: one flash read per beat,
//   the 64-bit word returned on R with backpressure. Beats outside the flash
//   window, with size > 3, or with WRAP/reserved bursts are answered SLVERR
//   with zero data and no flash access.
//
// Ports
//   clock, reset          : rising-edge clock, asynchronous active-high reset
//   ar_valid/ar_ready     : AR handshake (ar_ready registered, high only in IDLE)
//   ar_id/addr/len/size/burst : AR payload
//   r_valid/r_ready       : R handshake
//   r_id/r_data/r_resp/r_last : R payload, held stable while stalled
//   flash_r_en            : one-cycle flash read strobe per legal beat
//   flash_r_addr          : 8-byte aligned byte offset into the flash
//   flash_r_data          : flash word, valid the cycle after flash_r_en
module flash_axi_reader #(
  parameter logic [31:0] FLASH_BASE = 32'h1000_0000,
  parameter logic [31:0] FLASH_SIZE = 32'h0040_0000,
  parameter int unsigned ID_W       = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            ar_valid,
  output logic            ar_ready,
  input  logic [ID_W-1:0] ar_id,
  input  logic [31:0]     ar_addr,
  input  logic [7:0]      ar_len,
  input  logic [2:0]      ar_size,
  input  logic [1:0]      ar_burst,
  output logic            r_valid,
  input  logic            r_ready,
  output logic [ID_W-1:0] r_id,
  output logic [63:0]     r_data,
  output logic [1:0]      r_resp,
  output logic            r_last,
  output logic            flash_r_en,
  output logic [31:0]     flash_r_addr,
  input  logic [63:0]     flash_r_data
);

  typedef enum logic [1:0] {IDLE, REQ, CAP, RESP} state_t;

  state_t          state, state_nx;
  logic [ID_W-1:0] id_q;
  logic [31:0]     addr_q;
  logic [7:0]      len_q;
  logic [7:0]      beat_q;
  logic [2:0]      size_q;
  logic [1:0]      burst_q;
  logic            err_q;

  logic [31:0]     offset;
  logic [31:0]     ar_off;
  logic [31:0]     adv_off;
  logic [31:0]     addr_adv;
  logic [31:0]     size_bytes;
  logic            beat_legal;
  logic            ar_hs;
  logic            r_hs;

  // Beat legality and address advance for the current beat address.
  always_comb begin
    offset     = addr_q - FLASH_BASE;
    ar_off     = ar_addr - FLASH_BASE;
    beat_legal = (addr_q >= FLASH_BASE) && (offset < FLASH_SIZE) &&
                 (size_q <= 3'd3) && (burst_q[1] == 1'b0);
    size_bytes = 32'd1 << size_q;
    addr_adv   = (burst_q == 2'b01) ? ((addr_q & ~(size_bytes - 32'd1)) + size_bytes)
                                    : addr_q;
    adv_off    = addr_adv - FLASH_BASE;
  end

  always_comb begin
    state_nx   = state;
    flash_r_en = 1'b0;
    r_valid    = 1'b0;
    ar_hs      = (state == IDLE) && ar_valid && ar_ready;
    r_hs       = (state == RESP) && r_ready;
    case (state)
      IDLE: if (ar_hs) state_nx = REQ;
      REQ: begin
        flash_r_en = beat_legal;
        state_nx   = CAP;
      end
      CAP: state_nx = RESP;
      RESP: begin
        r_valid = 1'b1;
        if (r_ready) state_nx = r_last ? IDLE : REQ;
      end
      default: state_nx = IDLE;
    endcase
  end

  // ar_ready follows the next state so it rises one edge after reset release
  // and one edge after the last-beat handshake.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ar_ready <= 1'b0;
    end else begin
      state    <= state_nx;
      ar_ready <= (state_nx == IDLE);
    end
  end

  // flash_r_addr is loaded on entry to REQ (AR accept or R handshake), so it
  // is already valid during REQ and untouched through an R stall.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      id_q         <= '0;
      addr_q       <= '0;
      len_q        <= '0;
      beat_q       <= '0;
      size_q       <= '0;
      burst_q      <= '0;
      err_q        <= 1'b0;
      flash_r_addr <= '0;
      r_data       <= '0;
      r_resp       <= '0;
      r_last       <= 1'b0;
      r_id         <= '0;
    end else begin
      case (state)
        IDLE: if (ar_hs) begin
          id_q         <= ar_id;
          addr_q       <= ar_addr;
          len_q        <= ar_len;
          size_q       <= ar_size;
          burst_q      <= ar_burst;
          beat_q       <= '0;
          flash_r_addr <= ar_off & ~32'h7;
        end
        REQ: err_q <= ~beat_legal;
        CAP: begin
          r_data <= err_q ? '0 : flash_r_data;
          r_resp <= err_q ? 2'b10 : 2'b00;
          r_last <= (beat_q == len_q);
          r_id   <= id_q;
        end
        RESP: if (r_hs && !r_last) begin
          beat_q       <= beat_q + 8'd1;
          addr_q       <= addr_adv;
          flash_r_addr <= adv_off & ~32'h7;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_axi_reader.sv
module tb_flash_axi_reader;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [31:0] SIZE = 32'h0040_0000;
  localparam int unsigned IDW  = 4;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            ar_valid = 1'b0;
  logic            ar_ready;
  logic [IDW-1:0]  ar_id = '0;
  logic [31:0]     ar_addr = '0;
  logic [7:0]      ar_len = '0;
  logic [2:0]      ar_size = '0;
  logic [1:0]      ar_burst = '0;
  logic            r_valid;
  logic            r_ready = 1'b0;
  logic [IDW-1:0]  r_id;
  logic [63:0]     r_data;
  logic [1:0]      r_resp;
  logic            r_last;
  logic            flash_r_en;
  logic [31:0]     flash_r_addr;
  logic [63:0]     flash_r_data = '0;

  flash_axi_reader #(
    .FLASH_BASE(BASE),
    .FLASH_SIZE(SIZE),
    .ID_W(IDW)
  ) dut (
    .clock(clock), .reset(reset),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_id(ar_id), .ar_addr(ar_addr),
    .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
    .r_valid(r_valid), .r_ready(r_ready), .r_id(r_id), .r_data(r_data),
    .r_resp(r_resp), .r_last(r_last),
    .flash_r_en(flash_r_en), .flash_r_addr(flash_r_addr), .flash_r_data(flash_r_data)
  );

  always #5 clock = ~clock;

  // Flash contents: one fixed word from the test plan, a pattern elsewhere.
  function automatic logic [63:0] mem_word(input logic [31:0] off);
    if (off == 32'h8) return 64'h1122_3344_5566_7788;
    return {off ^ 32'h5A5A_0000, ~off};
  endfunction

  always @(posedge clock) if (flash_r_en) flash_r_data <= mem_word(flash_r_addr);

  typedef struct {
    logic [63:0]    data;
    logic [1:0]     resp;
    logic           last;
    logic [IDW-1:0] id;
    logic           legal;
    logic [31:0]    off;
  } beat_t;

  beat_t       exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          ref_cyc = 0;
  int          ar_cyc = 0;
  bit          m_busy = 1'b0;
  bit          m_ready = 1'b0;
  logic        prev_rv = 1'b0;
  logic [31:0] flash_log[$];
  logic [1:0]  resp_log[$];
  logic [63:0] data_log[$];
  logic [IDW-1:0] id_log[$];
  logic        last_log[$];
  int          en_cyc_log[$];
  int          rv_cyc_log[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected beat list straight from the burst rules.
  function automatic void plan_burst(input logic [IDW-1:0] id, input logic [31:0] addr,
                                     input logic [7:0] len, input logic [2:0] size,
                                     input logic [1:0] burst);
    logic [31:0] a;
    logic [32:0] lim;
    logic [31:0] step;
    beat_t b;
    a    = addr;
    lim  = {1'b0, BASE} + {1'b0, SIZE};
    step = 32'd1 << size;
    for (int i = 0; i <= int'(len); i++) begin
      b.legal = ({1'b0, a} >= {1'b0, BASE}) && ({1'b0, a} < lim) &&
                (size <= 3'd3) && (burst == 2'b00 || burst == 2'b01);
      b.off   = ((a - BASE) / 32'd8) * 32'd8;
      b.data  = b.legal ? mem_word(b.off) : 64'd0;
      b.resp  = b.legal ? 2'b00 : 2'b10;
      b.last  = (i == int'(len));
      b.id    = id;
      exp_q.push_back(b);
      if (burst == 2'b01) a = a - (a % step) + step;
    end
  endfunction

  // Per-cycle comparison against the model, then model advance for the
  // handshakes that will happen at the next rising edge.
  always @(negedge clock) begin
    logic exp_rv;
    logic exp_en;
    cyc++;
    if (reset) begin
      chk("rst_ar_ready", 64'(ar_ready), 64'd0);
      chk("rst_r_valid", 64'(r_valid), 64'd0);
      chk("rst_flash_r_en", 64'(flash_r_en), 64'd0);
      chk("rst_r_data", r_data, 64'd0);
      chk("rst_r_resp", 64'(r_resp), 64'd0);
      chk("rst_r_last", 64'(r_last), 64'd0);
      chk("rst_r_id", 64'(r_id), 64'd0);
      chk("rst_flash_r_addr", 64'(flash_r_addr), 64'd0);
      exp_q.delete();
      m_busy  = 1'b0;
      m_ready = 1'b0;
      prev_rv = 1'b0;
    end else begin
      exp_rv = m_busy && (cyc >= ref_cyc + 3);
      exp_en = m_busy && (cyc == ref_cyc + 1) && (exp_q.size() > 0) && exp_q[0].legal;
      chk("ar_ready", 64'(ar_ready), 64'(m_ready));
      chk("r_valid", 64'(r_valid), 64'(exp_rv));
      chk("flash_r_en", 64'(flash_r_en), 64'(exp_en));
      if (flash_r_en) begin
        flash_log.push_back(flash_r_addr);
        en_cyc_log.push_back(cyc);
        if (exp_en) chk("flash_r_addr", 64'(flash_r_addr), 64'(exp_q[0].off));
      end
      if (r_valid && !prev_rv) rv_cyc_log.push_back(cyc);
      if (r_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL r_beat_unexpected: got r_valid=1 expected no beat (t=%0t)", $time);
        end else begin
          chk("r_data", r_data, exp_q[0].data);
          chk("r_resp", 64'(r_resp), 64'(exp_q[0].resp));
          chk("r_last", 64'(r_last), 64'(exp_q[0].last));
          chk("r_id", 64'(r_id), 64'(exp_q[0].id));
        end
      end
      prev_rv = r_valid;
      if (ar_valid && m_ready) begin
        plan_burst(ar_id, ar_addr, ar_len, ar_size, ar_burst);
        m_busy  = 1'b1;
        ref_cyc = cyc;
        ar_cyc  = cyc;
      end
      if (r_valid && r_ready && exp_q.size() > 0) begin
        resp_log.push_back(r_resp);
        data_log.push_back(r_data);
        id_log.push_back(r_id);
        last_log.push_back(r_last);
        if (exp_q[0].last) m_busy = 1'b0;
        else ref_cyc = cyc;
        void'(exp_q.pop_front());
      end
      m_ready = !m_busy;
    end
  end

  task automatic clear_logs();
    flash_log.delete(); resp_log.delete(); data_log.delete();
    id_log.delete(); last_log.delete(); en_cyc_log.delete(); rv_cyc_log.delete();
  endtask

  task automatic send_ar(input logic [IDW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int g = 0;
    ar_id = id; ar_addr = addr; ar_len = len; ar_size = size; ar_burst = burst;
    ar_valid = 1'b1;
    @(negedge clock);
    while (!ar_ready && g < 200) begin
      @(negedge clock);
      g++;
    end
    if (!ar_ready) chk("ar_timeout", 64'(ar_ready), 64'd1);
    @(posedge clock); #1;
    ar_valid = 1'b0;
  endtask

  task automatic run_r(input int stall_beat, input int stall_len, input bit rnd);
    int  beat = 0;
    int  st = 0;
    int  g = 0;
    logic hs;
    while (m_busy && g < 1000) begin
      if (r_valid) begin
        if (beat == stall_beat && st < stall_len) begin
          r_ready = 1'b0;
          st++;
        end else r_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      end else r_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      hs = r_valid && r_ready;
      @(posedge clock); #1;
      g++;
      if (hs) beat++;
    end
    r_ready = 1'b0;
    if (m_busy) chk("r_timeout", 64'(m_busy), 64'd0);
  endtask

  task automatic wait_rvalid();
    int g = 0;
    while (!r_valid && g < 50) begin
      @(posedge clock); #1;
      g++;
    end
    chk("wait_rvalid", 64'(r_valid), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [2:0]  sz;
    logic [1:0]  bu;
    int          k;
    #1 reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock); #1;

    // Single read with latency pins.
    clear_logs();
    send_ar(4'd5, 32'h1000_0008, 8'd0, 3'd3, 2'b01);
    run_r(-1, 0, 1'b0);
    chk("single_n_reads", 64'(flash_log.size()), 64'd1);
    chk("single_n_beats", 64'(data_log.size()), 64'd1);
    if (flash_log.size() == 1) chk("single_addr", 64'(flash_log[0]), 64'h8);
    if (en_cyc_log.size() == 1) chk("single_en_lat", 64'(en_cyc_log[0] - ar_cyc), 64'd1);
    if (rv_cyc_log.size() == 1) chk("single_rv_lat", 64'(rv_cyc_log[0] - ar_cyc), 64'd3);
    if (data_log.size() == 1) begin
      chk("single_data", data_log[0], 64'h1122_3344_5566_7788);
      chk("single_resp", 64'(resp_log[0]), 64'd0);
      chk("single_last", 64'(last_log[0]), 64'd1);
      chk("single_id", 64'(id_log[0]), 64'd5);
    end

    // INCR len 3 with a 5-cycle stall on beat 1.
    clear_logs();
    send_ar(4'd2, BASE, 8'd3, 3'd3, 2'b01);
    run_r(1, 5, 1'b0);
    chk("incr_n_reads", 64'(flash_log.size()), 64'd4);
    chk("incr_n_beats", 64'(last_log.size()), 64'd4);
    if (flash_log.size() == 4)
      for (int i = 0; i < 4; i++) chk("incr_addr", 64'(flash_log[i]), 64'(i * 8));
    if (last_log.size() == 4)
      for (int i = 0; i < 4; i++) chk("incr_last", 64'(last_log[i]), 64'(i == 3));

    // Out of range.
    clear_logs();
    send_ar(4'd1, 32'h1040_0000, 8'd0, 3'd3, 2'b01);
    run_r(-1, 0, 1'b0);
    chk("oor_n_reads", 64'(flash_log.size()), 64'd0);
    chk("oor_n_beats", 64'(data_log.size()), 64'd1);
    if (data_log.size() == 1) begin
      chk("oor_data", data_log[0], 64'd0);
      chk("oor_resp", 64'(resp_log[0]), 64'd2);
      chk("oor_last", 64'(last_log[0]), 64'd1);
    end

    // Window crossing.
    clear_logs();
    send_ar(4'd7, 32'h103F_FFF8, 8'd1, 3'd3, 2'b01);
    run_r(-1, 0, 1'b0);
    chk("cross_n_reads", 64'(flash_log.size()), 64'd1);
    if (flash_log.size() == 1) chk("cross_addr", 64'(flash_log[0]), 64'h3F_FFF8);
    chk("cross_n_beats", 64'(resp_log.size()), 64'd2);
    if (resp_log.size() == 2) begin
      chk("cross_data0", data_log[0], 64'h5A65_FFF8_FFC0_0007);
      chk("cross_resp0", 64'(resp_log[0]), 64'd0);
      chk("cross_resp1", 64'(resp_log[1]), 64'd2);
      chk("cross_data1", data_log[1], 64'd0);
    end

    // FIXED len 2.
    clear_logs();
    send_ar(4'd3, 32'h1000_0010, 8'd2, 3'd3, 2'b00);
    run_r(-1, 0, 1'b0);
    chk("fixed_n_reads", 64'(flash_log.size()), 64'd3);
    if (flash_log.size() == 3)
      for (int i = 0; i < 3; i++) chk("fixed_addr", 64'(flash_log[i]), 64'h10);

    // WRAP len 3.
    clear_logs();
    send_ar(4'd4, BASE, 8'd3, 3'd3, 2'b10);
    run_r(-1, 0, 1'b0);
    chk("wrap_n_reads", 64'(flash_log.size()), 64'd0);
    chk("wrap_n_beats", 64'(resp_log.size()), 64'd4);
    if (resp_log.size() == 4)
      for (int i = 0; i < 4; i++) chk("wrap_resp", 64'(resp_log[i]), 64'd2);

    // Reset while beat 1 of an INCR len 3 burst sits in RESP.
    send_ar(4'd6, BASE, 8'd3, 3'd3, 2'b01);
    wait_rvalid();
    r_ready = 1'b1;
    @(posedge clock); #1;
    r_ready = 1'b0;
    wait_rvalid();
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_r_valid", 64'(r_valid), 64'd0);
    chk("mid_rst_flash_r_en", 64'(flash_r_en), 64'd0);
    chk("mid_rst_ar_ready", 64'(ar_ready), 64'd0);
    chk("mid_rst_r_data", r_data, 64'd0);
    @(posedge clock);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    chk("rel_ar_ready", 64'(ar_ready), 64'd1);
    clear_logs();
    send_ar(4'd9, 32'h1000_0008, 8'd0, 3'd3, 2'b01);
    run_r(-1, 0, 1'b0);
    chk("post_rst_n_beats", 64'(data_log.size()), 64'd1);
    if (data_log.size() == 1) chk("post_rst_data", data_log[0], 64'h1122_3344_5566_7788);

    // Randomized bursts against the model.
    for (int n = 0; n < 60; n++) begin
      k = int'($urandom_range(0, 3));
      case (k)
        0: a = BASE + ($urandom % SIZE);
        1: a = BASE + SIZE - 32'($urandom_range(1, 4) * 8) + 32'($urandom_range(0, 7));
        2: a = $urandom;
        default: a = BASE - 32'($urandom_range(1, 16));
      endcase
      k  = int'($urandom_range(0, 9));
      sz = (k > 4) ? 3'd3 : 3'(k);
      k  = int'($urandom_range(0, 9));
      bu = (k < 5) ? 2'b01 : (k < 8) ? 2'b00 : (k == 8) ? 2'b10 : 2'b11;
      repeat ($urandom_range(0, 3)) begin
        @(posedge clock); #1;
      end
      send_ar(4'($urandom), a, 8'($urandom_range(0, 7)), sz, bu);
      run_r(-1, 0, 1'b1);
    end

    repeat (3) @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
